// File: rtl/light_tracker_if.sv
// light_tracker_if: pixel stream into the tracker and per-frame spot results out.
// master = camera/pixel source side, slave = light_tracker.
interface light_tracker_if;
  logic       frame_start;
  logic       frame_end;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [7:0] pix_luma;

  logic [9:0] X_center_before_r;
  logic [9:0] Y_center_before_r;
  logic [9:0] X_MOVE_right_r;
  logic [9:0] X_MOVE_left_r;
  logic [9:0] Y_MOVE_down_r;
  logic [9:0] Y_MOVE_up_r;
  logic       is_light;
  logic       frame_done;

  modport master (
    output frame_start, frame_end, pix_valid, pix_x, pix_y, pix_luma,
    input  X_center_before_r, Y_center_before_r,
    input  X_MOVE_right_r, X_MOVE_left_r, Y_MOVE_down_r, Y_MOVE_up_r,
    input  is_light, frame_done
  );

  modport slave (
    input  frame_start, frame_end, pix_valid, pix_x, pix_y, pix_luma,
    output X_center_before_r, Y_center_before_r,
    output X_MOVE_right_r, X_MOVE_left_r, Y_MOVE_down_r, Y_MOVE_up_r,
    output is_light, frame_done
  );
endinterface

// File: rtl/light_tracker.sv
// light_tracker: finds the light-gun LED spot in the camera stream as the
// bounding-box midpoint of bright pixels, once per frame, and reports the
// centre, per-axis movement since the last valid centre and a light flag.
// Optional build macro: LIGHT_TRACKER_SMOOTH_EN -- loads the average of the
// new and previous centre (2-tap IIR) instead of the raw centre.
module light_tracker #(
  parameter logic [7:0]  THRESH  = 8'd200,
  parameter logic [18:0] MIN_PIX = 19'd16,
  parameter int          H_ACT   = 640,
  parameter int          V_ACT   = 480
) (
  input logic           Clk,
  input logic           Reset,
  light_tracker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

  localparam logic [10:0] H_LIM = 11'(H_ACT);
  localparam logic [10:0] V_LIM = 11'(V_ACT);

  state_t      state_reg;
  logic [9:0]  min_x_reg, max_x_reg, min_y_reg, max_y_reg;
  logic [18:0] cnt_reg;
  logic [9:0]  min_x_next, max_x_next, min_y_next, max_y_next;
  logic [18:0] cnt_next;

  logic [9:0]  center_x_reg, center_y_reg;
  logic [9:0]  right_reg, left_reg, down_reg, up_reg;
  logic        light_reg, done_reg;

  logic        in_area, bright, frame_ok;
  logic [10:0] cx, cy, tgt_x, tgt_y;
  logic signed [10:0] dx, dy, ndx, ndy;
  logic [9:0]  right_next, left_next, down_next, up_next;

  // Bright-pixel qualification: valid, above threshold, inside the active area.
  always_comb begin
    in_area = ({1'b0, bus.pix_x} < H_LIM) && ({1'b0, bus.pix_y} < V_LIM);
    bright  = bus.pix_valid && (bus.pix_luma >= THRESH) && in_area;
  end

  // Next accumulator values: cleared outside ACCUM and on an abandoned frame,
  // otherwise widened by the current bright pixel (frame_end cycle included).
  always_comb begin
    min_x_next = 10'h3FF;
    min_y_next = 10'h3FF;
    max_x_next = '0;
    max_y_next = '0;
    cnt_next   = '0;
    if (state_reg == ACCUM && (bus.frame_end || !bus.frame_start)) begin
      min_x_next = min_x_reg;
      min_y_next = min_y_reg;
      max_x_next = max_x_reg;
      max_y_next = max_y_reg;
      cnt_next   = cnt_reg;
      if (bright) begin
        if (bus.pix_x < min_x_reg) min_x_next = bus.pix_x;
        if (bus.pix_x > max_x_reg) max_x_next = bus.pix_x;
        if (bus.pix_y < min_y_reg) min_y_next = bus.pix_y;
        if (bus.pix_y > max_y_reg) max_y_next = bus.pix_y;
        if (cnt_reg != '1) cnt_next = cnt_reg + 19'd1;
      end
    end
  end

  // Centre and movement for the UPDATE cycle, always relative to the old centre.
  always_comb begin
    frame_ok = (cnt_reg >= MIN_PIX);
    cx = ({1'b0, min_x_reg} + {1'b0, max_x_reg}) >> 1;
    cy = ({1'b0, min_y_reg} + {1'b0, max_y_reg}) >> 1;
`ifdef LIGHT_TRACKER_SMOOTH_EN
    tgt_x = (cx + {1'b0, center_x_reg}) >> 1;
    tgt_y = (cy + {1'b0, center_y_reg}) >> 1;
`else
    tgt_x = cx;
    tgt_y = cy;
`endif
    dx  = $signed(tgt_x) - $signed({1'b0, center_x_reg});
    dy  = $signed(tgt_y) - $signed({1'b0, center_y_reg});
    ndx = -dx;
    ndy = -dy;
    right_next = (dx > 0) ? dx[9:0]  : 10'd0;
    left_next  = (dx < 0) ? ndx[9:0] : 10'd0;
    down_next  = (dy > 0) ? dy[9:0]  : 10'd0;
    up_next    = (dy < 0) ? ndy[9:0] : 10'd0;
  end

  // Frame FSM with registered accumulators and result outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      min_x_reg    <= 10'h3FF;
      min_y_reg    <= 10'h3FF;
      max_x_reg    <= '0;
      max_y_reg    <= '0;
      cnt_reg      <= '0;
      center_x_reg <= 10'd320;
      center_y_reg <= 10'd240;
      right_reg    <= '0;
      left_reg     <= '0;
      down_reg     <= '0;
      up_reg       <= '0;
      light_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      min_x_reg <= min_x_next;
      min_y_reg <= min_y_next;
      max_x_reg <= max_x_next;
      max_y_reg <= max_y_next;
      cnt_reg   <= cnt_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.frame_start) state_reg <= ACCUM;
        end
        ACCUM: begin
          if (bus.frame_end) state_reg <= UPDATE;
        end
        UPDATE: begin
          done_reg  <= 1'b1;
          state_reg <= IDLE;
          if (frame_ok) begin
            center_x_reg <= tgt_x[9:0];
            center_y_reg <= tgt_y[9:0];
            right_reg    <= right_next;
            left_reg     <= left_next;
            down_reg     <= down_next;
            up_reg       <= up_next;
            light_reg    <= 1'b1;
          end else begin
            right_reg    <= '0;
            left_reg     <= '0;
            down_reg     <= '0;
            up_reg       <= '0;
            light_reg    <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.X_center_before_r = center_x_reg;
  assign bus.Y_center_before_r = center_y_reg;
  assign bus.X_MOVE_right_r    = right_reg;
  assign bus.X_MOVE_left_r     = left_reg;
  assign bus.Y_MOVE_down_r     = down_reg;
  assign bus.Y_MOVE_up_r       = up_reg;
  assign bus.is_light          = light_reg;
  assign bus.frame_done        = done_reg;

endmodule
